// File: rtl/ahb_pkg.sv
// Shared AHB encodings (HTRANS, HBURST) and arbiter state constants, reused by
// the arbiter, the decoder and the slaves.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] ARB_IDLE    = 2'b00;
   localparam logic [1:0] ARB_GRANTED = 2'b01;
   localparam logic [1:0] ARB_BURST   = 2'b10;
   localparam logic [1:0] ARB_LOCKED  = 2'b11;

   // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
   function automatic logic [3:0] burstLoad(input logic [2:0] hburst);
      case (hburst[2:1])
         2'b01:   return 4'd3;
         2'b10:   return 4'd7;
         2'b11:   return 4'd15;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic isFixedBurst(input logic [2:0] hburst);
      return hburst[2:1] != 2'b00;
   endfunction

endpackage

// File: rtl/ahb_rr_select.sv
// Round-robin selector: picks the first requester strictly after the pointer,
// wrapping around, and returns it one-hot.
module ahb_rr_select #(
   parameter int N  = 2,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);

   logic [PW-1:0]  shamt;
   logic [N-1:0]   rotReq;
   logic [N-1:0]   rotGrant;
   logic [2*N-1:0] grantDbl;

   // Rotate so the slot after the pointer sits at bit 0, isolate the lowest set
   // bit, then rotate back.
   always_comb begin
      shamt    = ptr_i + {{(PW-1){1'b0}}, 1'b1};
      rotReq   = N'({req_i, req_i} >> shamt);
      rotGrant = rotReq & (-rotReq);
      grantDbl = {{N{1'b0}}, rotGrant} << shamt;
      grant_o  = grantDbl[N-1:0] | grantDbl[2*N-1:N];
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-burst, INCR and locked-transfer
// holding; address and data phase owner indices for the bus muxes.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int MASTER_DEVICES = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                              ahb_clk_in,
   input  logic                              ahb_rst_in,
   input  logic [MASTER_DEVICES-1:0]         master_req_in,
   input  logic [MASTER_DEVICES-1:0]         master_lock_in,
   input  logic [1:0]                        ahb_htrans_in,
   input  logic [2:0]                        ahb_hburst_in,
   input  logic                              ahb_hready_in,
   output logic [MASTER_DEVICES-1:0]         master_grant_out,
   output logic [$clog2(MASTER_DEVICES):0]   addr_master_out,
   output logic [$clog2(MASTER_DEVICES):0]   data_master_out,
   output logic                              master_locked_out
);

   localparam int IW = $clog2(MASTER_DEVICES) + 1;
   localparam logic [MASTER_DEVICES-1:0] DEFAULT_GRANT =
      {{(MASTER_DEVICES-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [IW-1:0] DEFAULT_IDX = IW'(DEFAULT_MASTER);

   logic [1:0]                state_q, state_d;
   logic [MASTER_DEVICES-1:0] grant_q, grant_d;
   logic [IW-1:0]             addrMaster_q, addrMaster_d;
   logic [IW-1:0]             dataMaster_q, dataMaster_d;
   logic [IW-1:0]             ptr_q, ptr_d;
   logic [3:0]                beatCnt_q, beatCnt_d;
   logic                      lockTail_q, lockTail_d;

   logic [MASTER_DEVICES-1:0] winner;
   logic [IW-1:0]             winnerIdx;
   logic [IW-1:0]             ownerIdx;
   logic                      anyReq;
   logic                      ownerReq;
   logic                      ownerLock;
   logic                      incrHold;
   logic                      evalNew;
   logic                      doArb;

   ahb_rr_select #(
      .N  (MASTER_DEVICES),
      .PW (IW)
   ) uRrSelect (
      .req_i   (master_req_in),
      .ptr_i   (ptr_q),
      .grant_o (winner)
   );

   // The granted master is the one whose HTRANS/HBURST the hold decisions look at.
   always_comb begin
      ownerIdx  = '0;
      winnerIdx = '0;
      for (int i = 0; i < MASTER_DEVICES; i++) begin
         if (grant_q[i]) ownerIdx = IW'(i);
         if (winner[i])  winnerIdx = IW'(i);
      end
      anyReq    = |master_req_in;
      ownerReq  = |(master_req_in & grant_q);
      ownerLock = |(master_lock_in & grant_q);
      incrHold  = ownerReq && ((ahb_htrans_in == HTRANS_SEQ) || (ahb_htrans_in == HTRANS_BUSY) ||
                  ((ahb_htrans_in == HTRANS_NONSEQ) && (ahb_hburst_in == HBURST_INCR)));
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      addrMaster_d = addrMaster_q;
      dataMaster_d = dataMaster_q;
      ptr_d        = ptr_q;
      beatCnt_d    = beatCnt_q;
      lockTail_d   = lockTail_q;
      evalNew      = 1'b0;
      doArb        = 1'b0;
      if (ahb_hready_in) begin
         addrMaster_d = ownerIdx;
         dataMaster_d = addrMaster_q;
         case (state_q)
            ARB_LOCKED: begin
               if (ownerLock) begin
                  lockTail_d = 1'b0;
               end else if (!lockTail_q) begin
                  lockTail_d = 1'b1;
               end else begin
                  lockTail_d = 1'b0;
                  doArb      = 1'b1;
               end
            end
            ARB_BURST: begin
               if (ahb_htrans_in == HTRANS_SEQ) begin
                  if (beatCnt_q <= 4'd1) begin
                     beatCnt_d = 4'd0;
                     doArb     = 1'b1;
                  end else begin
                     beatCnt_d = beatCnt_q - 4'd1;
                  end
               end else if (ahb_htrans_in != HTRANS_BUSY) begin
                  beatCnt_d = 4'd0;
                  evalNew   = 1'b1;
               end
            end
            default: evalNew = 1'b1;
         endcase
         if (evalNew) begin
            if (ownerLock) begin
               state_d    = ARB_LOCKED;
               lockTail_d = 1'b0;
            end else if ((ahb_htrans_in == HTRANS_NONSEQ) && isFixedBurst(ahb_hburst_in)) begin
               state_d   = ARB_BURST;
               beatCnt_d = burstLoad(ahb_hburst_in);
            end else if (incrHold) begin
               state_d = ARB_GRANTED;
            end else begin
               doArb = 1'b1;
            end
         end
         // The pointer only moves on a real win so idle periods keep the rotation.
         if (doArb) begin
            if (anyReq) begin
               grant_d = winner;
               ptr_d   = winnerIdx;
               state_d = ARB_GRANTED;
            end else begin
               grant_d = DEFAULT_GRANT;
               state_d = ARB_IDLE;
            end
         end
      end
   end

   always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
      if (ahb_rst_in) begin
         state_q      <= ARB_IDLE;
         grant_q      <= DEFAULT_GRANT;
         addrMaster_q <= DEFAULT_IDX;
         dataMaster_q <= DEFAULT_IDX;
         ptr_q        <= DEFAULT_IDX;
         beatCnt_q    <= 4'd0;
         lockTail_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         addrMaster_q <= addrMaster_d;
         dataMaster_q <= dataMaster_d;
         ptr_q        <= ptr_d;
         beatCnt_q    <= beatCnt_d;
         lockTail_q   <= lockTail_d;
      end
   end

   assign master_grant_out  = grant_q;
   assign addr_master_out   = addrMaster_q;
   assign data_master_out   = dataMaster_q;
   assign master_locked_out = (state_q == ARB_LOCKED);

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter MASTER_DEVICES, default 2, number of requesting masters, legal 2..4.
REQ-002 Parameter DEFAULT_MASTER, default 0, master granted when no requests pending.
REQ-003 Port ahb_clk_in  input  1  bus clock; all state on rising edge.
REQ-004 Port ahb_rst_in  input  1  reset, asynchronous, active-high.
REQ-005 Port master_req_in  input  MASTER_DEVICES  per-master bus request (HBUSREQx).
REQ-006 Port master_lock_in  input  MASTER_DEVICES  per-master locked-transfer request (HLOCKx).
REQ-007 Port ahb_htrans_in  input  2  HTRANS of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 Port ahb_hburst_in  input  3  HBURST of current owner (000 SINGLE, 001 INCR, 010/011 4-beat, 100/101 8-beat, 110/111 16-beat).
REQ-009 Port ahb_hready_in  input  1  HREADY from slave mux.
REQ-010 Port master_grant_out  output  MASTER_DEVICES  one-hot HGRANTx.
REQ-011 Port addr_master_out  output  $clog2(MASTER_DEVICES)+1  address-phase owner index (HMASTER), drives address mux.
REQ-012 Port data_master_out  output  $clog2(MASTER_DEVICES)+1  data-phase owner index, drives write-data mux.
REQ-013 Port master_locked_out  output  1  HMASTLOCK for current address phase.

Function
REQ-014 master_grant_out SHALL be one-hot at all times after reset.
REQ-015 States: IDLE (default master owns, no request), GRANTED (owner in non-burst/single transfers), BURST (fixed-length burst in progress), LOCKED (owner holds lock).
REQ-016 Arbitration SHALL be round-robin starting from the index after the last owner; default master takes the grant only when no request is asserted.
REQ-017 Re-arbitration SHALL take effect only on a rising edge with ahb_hready_in=1; grant output updates one cycle before the new owner's address phase (grant registered, addr_master_out follows grant on next hready-high edge).
REQ-018 In BURST, a beat counter SHALL load 3/7/15 on NONSEQ with 4/8/16-beat HBURST and decrement on each SEQ accepted with hready=1; grant SHALL be held until counter reaches 0, then re-arbitrate.
REQ-019 BUSY beats SHALL not decrement the counter.
REQ-020 INCR bursts SHALL hold grant while owner keeps master_req_in asserted and htrans is SEQ/BUSY; release on NONSEQ or IDLE after request drops.
REQ-021 LOCKED entered when owner asserts master_lock_in with its grant; grant held until master_lock_in drops, plus one further hready-high transfer; master_locked_out=1 throughout.
REQ-022 Owner dropping master_req_in during a fixed burst SHALL not shorten the burst.
REQ-023 ahb_hready_in=0 SHALL freeze grant, counters, addr_master_out and data_master_out.
REQ-024 data_master_out SHALL load addr_master_out on every rising edge with ahb_hready_in=1.
REQ-025 Simultaneous requests with no owner history: lowest index after DEFAULT_MASTER wins.
REQ-026 IDLE htrans from an owner that has dropped its request SHALL release the grant on that hready-high edge.

Reset
REQ-027 During ahb_rst_in=1: master_grant_out = one-hot DEFAULT_MASTER, addr_master_out = data_master_out = DEFAULT_MASTER, master_locked_out=0, state IDLE, beat counter 0, round-robin pointer DEFAULT_MASTER.
REQ-028 Reset mid-burst or mid-lock SHALL abort immediately to the REQ-027 values; first arbitration occurs on the first hready-high edge after release.

Structure
REQ-029 HTRANS and HBURST encodings and state encodings SHALL live in shared package ahb_pkg, reused by ahb_decoder and slaves.
REQ-030 Round-robin priority selection SHALL be a sub-module ahb_rr_select (request vector + pointer -> one-hot winner).

Verification
REQ-031 Reset: hold ahb_rst_in=1 -> grant=01, addr/data master=0, locked=0.
REQ-032 Req=11, SINGLE NONSEQ each cycle, hready=1 -> grant alternates 01,10,01 every transfer.
REQ-033 Master1 4-beat NONSEQ+3 SEQ with master0 requesting and one hready=0 cycle mid-burst -> grant stays 10 for 5 cycles, switches to 01 after fourth beat.
REQ-034 Master0 lock asserted for 3 transfers while master1 requests -> grant held 01, locked=1 until one transfer after lock drops.
REQ-035 INCR burst by master1, request dropped, htrans IDLE -> grant returns to DEFAULT_MASTER on that edge; data_master_out lags addr_master_out by one hready-high edge.
REQ-036 Assert ahb_rst_in mid 8-beat burst -> outputs immediately at reset values, counter 0.
